// File: rtl/mem_write_checker.sv
// Watches a memory store bus and checks it against a small programmable table of
// expected (address, data) writes, reporting pass, data mismatch or timeout.
module mem_write_checker #(
  parameter  int ADDR_W     = 32,
  parameter  int DATA_W     = 32,
  parameter  int NUM_CHECKS = 4,
  parameter  int TIMEOUT    = 1024,
  parameter  int ORDERED    = 1,
  localparam int IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int CNT_W      = $clog2(NUM_CHECKS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Adr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              CfgWe,
  input  logic [IDX_W-1:0]  CfgIdx,
  input  logic [ADDR_W-1:0] CfgAdr,
  input  logic [DATA_W-1:0] CfgData,
  input  logic              Start,
  output logic              Busy,
  output logic              Pass,
  output logic              Fail,
  output logic [1:0]        FailCode,
  output logic [CNT_W-1:0]  MatchCount,
  output logic [31:0]       CycleCount
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_DATA    = 2'd2;

  state_t                  state;
  logic [ADDR_W-1:0]       exp_adr  [NUM_CHECKS];
  logic [DATA_W-1:0]       exp_data [NUM_CHECKS];
  logic [NUM_CHECKS-1:0]   hit_mask;

  logic                    addr_hit;
  logic                    data_ok;
  logic [NUM_CHECKS-1:0]   hit_onehot;
  logic                    write_match;
  logic                    write_mismatch;
  logic                    last_match;
  logic                    at_timeout;

  // Pick the single table entry this cycle's write is judged against.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value held over, which would otherwise infer a latch.
    addr_hit   = 1'b0;
    data_ok    = 1'b0;
    hit_onehot = '0;
    if (ORDERED != 0) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        if (MatchCount == CNT_W'(i) && Adr == exp_adr[i]) begin
          addr_hit      = 1'b1;
          data_ok       = (WriteData == exp_data[i]);
          hit_onehot    = '0;
          hit_onehot[i] = 1'b1;
        end
      end
    end else begin
      // Walk downwards so the lowest matching unhit entry is the one that sticks.
      for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
        if (!hit_mask[i] && Adr == exp_adr[i]) begin
          // NOTE: blocking assignments here are intentional; later loop
          // iterations overwrite earlier ones within the same evaluation.
          addr_hit      = 1'b1;
          data_ok       = (WriteData == exp_data[i]);
          hit_onehot    = '0;
          hit_onehot[i] = 1'b1;
        end
      end
    end
  end

  assign write_match    = MemWrite && addr_hit && data_ok;
  assign write_mismatch = MemWrite && addr_hit && !data_ok;
  assign last_match     = write_match && (MatchCount == CNT_W'(NUM_CHECKS - 1));
  assign at_timeout     = (CycleCount == 32'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      Busy       <= 1'b0;
      Pass       <= 1'b0;
      Fail       <= 1'b0;
      FailCode   <= FC_NONE;
      MatchCount <= '0;
      CycleCount <= '0;
      hit_mask   <= '0;
      // NOTE: table storage is normally left unreset, but this checker must come
      // out of reset with every entry at address 0 / data 0, so it is flops.
      for (int i = 0; i < NUM_CHECKS; i++) begin
        exp_adr[i]  <= '0;
        exp_data[i] <= '0;
      end
    end else begin
      if (CfgWe && state != S_RUN) begin
        for (int i = 0; i < NUM_CHECKS; i++) begin
          if (CfgIdx == IDX_W'(i)) begin
            exp_adr[i]  <= CfgAdr;
            exp_data[i] <= CfgData;
          end
        end
      end

      case (state)
        S_RUN: begin
          // Completion beats both mismatch and timeout; mismatch beats timeout.
          if (last_match) begin
            state      <= S_PASS;
            Busy       <= 1'b0;
            Pass       <= 1'b1;
            MatchCount <= MatchCount + CNT_W'(1);
            hit_mask   <= hit_mask | hit_onehot;
          end else if (write_mismatch) begin
            state    <= S_FAIL;
            Busy     <= 1'b0;
            Fail     <= 1'b1;
            FailCode <= FC_DATA;
          end else if (at_timeout) begin
            state    <= S_FAIL;
            Busy     <= 1'b0;
            Fail     <= 1'b1;
            FailCode <= FC_TIMEOUT;
          end else begin
            if (CycleCount != '1) CycleCount <= CycleCount + 32'd1;
            if (write_match) begin
              MatchCount <= MatchCount + CNT_W'(1);
              hit_mask   <= hit_mask | hit_onehot;
            end
          end
        end
        default: begin
          if (Start) begin
            state      <= S_RUN;
            Busy       <= 1'b1;
            Pass       <= 1'b0;
            Fail       <= 1'b0;
            FailCode   <= FC_NONE;
            MatchCount <= '0;
            CycleCount <= '0;
            hit_mask   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Drives an ordered and an unordered checker with the same directed stimulus and
// compares both against a table-based model every cycle, plus literal spot checks.
module tb_mem_write_checker;

  localparam int NC = 2;
  localparam int TO = 16;

  typedef enum int {M_IDLE, M_RUN, M_PASS, M_FAIL} mphase_t;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic        CfgWe;
  logic [0:0]  CfgIdx;
  logic [31:0] CfgAdr;
  logic [31:0] CfgData;
  logic        Start;

  logic        o_busy, o_pass, o_fail, u_busy, u_pass, u_fail;
  logic [1:0]  o_code, u_code, o_mc, u_mc;
  logic [31:0] o_cc, u_cc;

  int errors = 0;
  int checks = 0;

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_CHECKS(NC), .TIMEOUT(TO), .ORDERED(1)) dut_o (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
    .CfgWe(CfgWe), .CfgIdx(CfgIdx), .CfgAdr(CfgAdr), .CfgData(CfgData), .Start(Start),
    .Busy(o_busy), .Pass(o_pass), .Fail(o_fail), .FailCode(o_code),
    .MatchCount(o_mc), .CycleCount(o_cc)
  );

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_CHECKS(NC), .TIMEOUT(TO), .ORDERED(0)) dut_u (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
    .CfgWe(CfgWe), .CfgIdx(CfgIdx), .CfgAdr(CfgAdr), .CfgData(CfgData), .Start(Start),
    .Busy(u_busy), .Pass(u_pass), .Fail(u_fail), .FailCode(u_code),
    .MatchCount(u_mc), .CycleCount(u_cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index 0 is the ordered checker, index 1 the unordered one.
  mphase_t     m_phase [2];
  int          m_code  [2];
  int          m_count [2];
  int          m_cycles[2];
  bit          m_hit   [2][NC];
  logic [31:0] m_adr   [2][NC];
  logic [31:0] m_data  [2][NC];
  bit          model_valid = 1'b0;

  function automatic int find_target(input int k);
    if (k == 0) return (Adr == m_adr[k][m_count[k]]) ? m_count[k] : -1;
    for (int i = 0; i < NC; i++)
      if (!m_hit[k][i] && Adr == m_adr[k][i]) return i;
    return -1;
  endfunction

  task automatic model_step(input int k);
    int target;
    bit matched;
    bit bad;
    if (reset) begin
      m_phase[k] = M_IDLE; m_code[k] = 0; m_count[k] = 0; m_cycles[k] = 0;
      for (int i = 0; i < NC; i++) begin
        m_hit[k][i] = 1'b0; m_adr[k][i] = '0; m_data[k][i] = '0;
      end
      model_valid = 1'b1;
      return;
    end
    if (m_phase[k] != M_RUN) begin
      if (CfgWe) begin
        m_adr[k][CfgIdx]  = CfgAdr;
        m_data[k][CfgIdx] = CfgData;
      end
      if (Start) begin
        m_phase[k] = M_RUN; m_code[k] = 0; m_count[k] = 0; m_cycles[k] = 0;
        for (int i = 0; i < NC; i++) m_hit[k][i] = 1'b0;
      end
      return;
    end
    target  = MemWrite ? find_target(k) : -1;
    matched = 1'b0;
    bad     = 1'b0;
    if (target >= 0) begin
      matched = (WriteData == m_data[k][target]);
      bad     = !matched;
    end
    if (matched && m_count[k] + 1 == NC) begin
      m_count[k]++; m_phase[k] = M_PASS;
    end else if (bad) begin
      m_phase[k] = M_FAIL; m_code[k] = 2;
    end else if (m_cycles[k] == TO - 1) begin
      m_phase[k] = M_FAIL; m_code[k] = 1;
    end else begin
      m_cycles[k]++;
      if (matched) begin
        m_count[k]++; m_hit[k][target] = 1'b1;
      end
    end
  endtask

  task automatic compare_inst(input string p, input int k, input logic busy, input logic pass,
                              input logic fail, input logic [1:0] code, input logic [1:0] mc,
                              input logic [31:0] cc);
    check({p, "Busy"},       32'(busy), 32'(m_phase[k] == M_RUN));
    check({p, "Pass"},       32'(pass), 32'(m_phase[k] == M_PASS));
    check({p, "Fail"},       32'(fail), 32'(m_phase[k] == M_FAIL));
    check({p, "FailCode"},   32'(code), 32'(m_code[k]));
    check({p, "MatchCount"}, 32'(mc),   32'(m_count[k]));
    check({p, "CycleCount"}, cc,        32'(m_cycles[k]));
    check({p, "exclusive"},  32'($countones({busy, pass, fail}) <= 1), 32'd1);
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    #1;
    if (model_valid) begin
      compare_inst("o.", 0, o_busy, o_pass, o_fail, o_code, o_mc, o_cc);
      compare_inst("u.", 1, u_busy, u_pass, u_fail, u_code, u_mc, u_cc);
    end
  end

  // Stimulus tasks are entered just after a falling edge and leave just after the next one.
  task automatic clr();
    MemWrite = 1'b0; Start = 1'b0; CfgWe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input logic idx, input logic [31:0] a, input logic [31:0] d);
    CfgWe = 1'b1; CfgIdx = idx; CfgAdr = a; CfgData = d;
    @(negedge clk); clr();
  endtask

  task automatic start();
    Start = 1'b1;
    @(negedge clk); clr();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; Adr = a; WriteData = d;
    @(negedge clk); clr();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clr();
    Adr = '0; WriteData = '0; CfgIdx = '0; CfgAdr = '0; CfgData = '0;
    idle(2);
    reset = 1'b0;
    check("reset Busy", 32'(o_busy), 0);
    check("reset Pass/Fail", 32'({o_pass, o_fail}), 0);
    check("reset MatchCount", 32'(o_mc), 0);
    check("reset CycleCount", o_cc, 0);

    // Ordered pass: out-of-order write ignored.
    cfg(1'b0, 32'h80, 32'hFE);
    cfg(1'b1, 32'h84, 32'h07);
    start();
    check("start Busy", 32'(o_busy), 1);
    wr(32'h84, 32'h07);
    check("ordered skip MatchCount", 32'(o_mc), 0);
    wr(32'h80, 32'hFE);
    check("ordered first MatchCount", 32'(o_mc), 1);
    wr(32'h84, 32'h07);
    check("ordered MatchCount", 32'(o_mc), 2);
    check("ordered Pass", 32'(o_pass), 1);
    check("ordered FailCode", 32'(o_code), 0);

    // Data mismatch.
    start();
    wr(32'h80, 32'hFF);
    check("mismatch Fail", 32'(o_fail), 1);
    check("mismatch FailCode", 32'(o_code), 2);
    check("mismatch MatchCount", 32'(o_mc), 0);

    // Timeout with no writes.
    start();
    idle(15);
    check("pre-timeout Busy", 32'(o_busy), 1);
    idle(1);
    check("timeout Fail", 32'(o_fail), 1);
    check("timeout FailCode", 32'(o_code), 1);
    check("timeout CycleCount", o_cc, 15);

    // Final match on the timeout cycle wins.
    start();
    wr(32'h80, 32'hFE);
    idle(14);
    check("edge CycleCount", o_cc, 15);
    wr(32'h84, 32'h07);
    check("edge Pass", 32'(o_pass), 1);
    check("edge FailCode", 32'(o_code), 0);

    // Unordered pass with a duplicate write.
    start();
    wr(32'h84, 32'h07);
    check("unordered first MatchCount", 32'(u_mc), 1);
    wr(32'h84, 32'h07);
    check("unordered dup MatchCount", 32'(u_mc), 1);
    wr(32'h80, 32'hFE);
    check("unordered MatchCount", 32'(u_mc), 2);
    check("unordered Pass", 32'(u_pass), 1);
    check("ordered mid-run MatchCount", 32'(o_mc), 1);

    // Reset mid-run aborts and clears the table to all (0,0).
    do_reset();
    check("abort Busy", 32'(o_busy), 0);
    check("abort MatchCount", 32'(o_mc), 0);
    check("abort Pass/Fail", 32'({o_pass, o_fail}), 0);
    start();
    wr(32'h0, 32'h0);
    wr(32'h0, 32'h0);
    check("cleared table Pass", 32'(o_pass), 1);

    // Config lockout and Start ignored while running.
    cfg(1'b0, 32'h80, 32'hFE);
    cfg(1'b1, 32'h84, 32'h07);
    start();
    cfg(1'b0, 32'h90, 32'h11);
    start();
    check("restart-in-run CycleCount", o_cc, 2);
    wr(32'h80, 32'hFE);
    check("locked cfg MatchCount", 32'(o_mc), 1);
    wr(32'h84, 32'h07);
    check("locked cfg Pass", 32'(o_pass), 1);

    // Reset overrides a same-edge Start.
    Start = 1'b1; reset = 1'b1;
    @(negedge clk); clr(); reset = 1'b0;
    check("reset over Start Busy", 32'(o_busy), 0);
    check("reset over Start Pass", 32'(o_pass), 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
